// File: rtl/game_tick_scheduler_pkg.sv
// Shared snake-game timing definitions: run-state encodings, default timing constants
// and the level-to-period mapping used by the tick scheduler.
package game_tick_scheduler_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_RUN   = 2'b01;
  localparam state_t ST_PAUSE = 2'b10;
  localparam state_t ST_OVER  = 2'b11;

  localparam int unsigned DEF_PIX_DIV          = 4;
  localparam int unsigned DEF_BASE_TICK_CYCLES = 10_000_000;
  localparam int unsigned DEF_STEP_CYCLES      = 1_000_000;
  localparam int unsigned DEF_MIN_TICK_CYCLES  = 2_000_000;
  localparam int unsigned DEF_APPLES_PER_LEVEL = 4;
  localparam int unsigned DEF_LEVEL_W          = 4;
  localparam int unsigned TICK_W               = 32;

  // Move-tick period for a level, floored at min_cyc; never wraps below zero.
  function automatic logic [TICK_W-1:0] tick_period(input logic [TICK_W-1:0] lvl,
                                                    input logic [TICK_W-1:0] base_cyc,
                                                    input logic [TICK_W-1:0] step_cyc,
                                                    input logic [TICK_W-1:0] min_cyc);
    logic [TICK_W-1:0] prod;
    logic [TICK_W-1:0] diff;
    prod = lvl * step_cyc;
    diff = base_cyc - prod;
    if (prod >= base_cyc || diff < min_cyc) begin
      return min_cyc;
    end
    return diff;
  endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Command/status bundle between the game logic (master) and the tick scheduler (slave).
interface game_tick_scheduler_if
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned LEVEL_W = DEF_LEVEL_W
) ();

  logic               start;
  logic               pause_toggle;
  logic               game_over;
  logic               apple_eaten;
  logic               move_done;
  logic               pixel_ce;
  logic               move_tick;
  logic               running;
  state_t             state;
  logic [LEVEL_W-1:0] level;
  logic               overrun;

  modport master (
    output start, pause_toggle, game_over, apple_eaten, move_done,
    input  pixel_ce, move_tick, running, state, level, overrun
  );

  modport slave (
    input  start, pause_toggle, game_over, apple_eaten, move_done,
    output pixel_ce, move_tick, running, state, level, overrun
  );

endinterface

// File: rtl/ce_divider.sv
// Free-running clock-enable strobe: one registered pulse every DIV cycles,
// first pulse on the DIV-th edge after reset release.
module ce_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clock_100Mhz,
  input  logic reset,
  output logic ce
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else begin
      ce  <= (cnt == CNT_LAST);
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Snake-game timing controller: pixel enable, level-scaled move tick with busy/overrun
// handshake, and the idle/run/pause/over run-state sequencer.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned PIX_DIV          = DEF_PIX_DIV,
  parameter int unsigned BASE_TICK_CYCLES = DEF_BASE_TICK_CYCLES,
  parameter int unsigned STEP_CYCLES      = DEF_STEP_CYCLES,
  parameter int unsigned MIN_TICK_CYCLES  = DEF_MIN_TICK_CYCLES,
  parameter int unsigned APPLES_PER_LEVEL = DEF_APPLES_PER_LEVEL,
  parameter int unsigned LEVEL_W          = DEF_LEVEL_W
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  game_tick_scheduler_if.slave bus
);

  localparam int unsigned APL_W = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;
  localparam logic [APL_W-1:0]   APPLE_LAST = APL_W'(APPLES_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;
  localparam logic [TICK_W-1:0]  BASE_P     = TICK_W'(BASE_TICK_CYCLES);

  state_t             state_q;
  state_t             state_d;
  logic [TICK_W-1:0]  tick_cnt;
  logic [TICK_W-1:0]  period_q;
  logic [APL_W-1:0]   apple_cnt;
  logic [LEVEL_W-1:0] level_q;
  logic               busy_q;
  logic               overrun_q;
  logic               move_tick_q;
  logic               running_q;
  logic               pixel_ce;

  logic go_over;
  logic restart;
  logic in_run;
  logic expiry;
  logic issue;

  ce_divider #(.DIV(PIX_DIV)) u_pix_ce (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .ce           (pixel_ce)
  );

  // Run-state register.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle decode; game_over beats start beats pause_toggle.
  always_comb begin
    state_d = state_q;
    go_over = bus.game_over && (state_q == ST_RUN || state_q == ST_PAUSE);
    restart = bus.start && !go_over;
    if (go_over) begin
      state_d = ST_OVER;
    end else if (bus.start) begin
      state_d = ST_RUN;
    end else if (bus.pause_toggle) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end else if (state_q == ST_PAUSE) begin
        state_d = ST_RUN;
      end
    end
    in_run = (state_q == ST_RUN) && !go_over && !restart;
    expiry = in_run && (tick_cnt == period_q - TICK_W'(1));
    issue  = expiry && (!busy_q || bus.move_done);
  end

  // Tick counter, period, apples/level and the move handshake.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      tick_cnt    <= '0;
      period_q    <= BASE_P;
      apple_cnt   <= '0;
      level_q     <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      move_tick_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      move_tick_q <= issue;
      running_q   <= (state_d == ST_RUN);
      if (restart) begin
        tick_cnt  <= '0;
        period_q  <= BASE_P;
        apple_cnt <= '0;
        level_q   <= '0;
        busy_q    <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        if (in_run) begin
          tick_cnt <= expiry ? '0 : tick_cnt + TICK_W'(1);
        end else if (go_over) begin
          tick_cnt <= '0;
        end
        // New speed takes effect only at interval boundaries.
        if (expiry) begin
          period_q <= tick_period(TICK_W'(level_q), BASE_P, TICK_W'(STEP_CYCLES),
                                  TICK_W'(MIN_TICK_CYCLES));
        end
        if (issue) begin
          busy_q <= 1'b1;
        end else if (bus.move_done) begin
          busy_q <= 1'b0;
        end
        if (expiry && !issue) begin
          overrun_q <= 1'b1;
        end
        if (in_run && bus.apple_eaten) begin
          if (apple_cnt == APPLE_LAST) begin
            apple_cnt <= '0;
            if (level_q != LEVEL_MAX) begin
              level_q <= level_q + LEVEL_W'(1);
            end
          end else begin
            apple_cnt <= apple_cnt + APL_W'(1);
          end
        end
      end
    end
  end

  assign bus.pixel_ce  = pixel_ce;
  assign bus.move_tick = move_tick_q;
  assign bus.running   = running_q;
  assign bus.state     = state_q;
  assign bus.level     = level_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with small timing parameters.
module tb_game_tick_scheduler;
  import game_tick_scheduler_pkg::*;

  logic clock_100Mhz;
  logic reset;

  game_tick_scheduler_if #(.LEVEL_W(2)) bus ();

  game_tick_scheduler #(
    .PIX_DIV          (4),
    .BASE_TICK_CYCLES (20),
    .STEP_CYCLES      (5),
    .MIN_TICK_CYCLES  (8),
    .APPLES_PER_LEVEL (2),
    .LEVEL_W          (2)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .bus          (bus)
  );

  initial begin
    clock_100Mhz = 1'b0;
    forever #5 clock_100Mhz = ~clock_100Mhz;
  end

  int n_vec;
  int n_miss;
  int cyc;
  int n_ticks;
  int done_dly;
  bit auto_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample just after the edge, drop pulses, run the move_done responder.
  task automatic step();
    @(posedge clock_100Mhz);
    #1;
    cyc++;
    if (bus.move_tick) n_ticks++;
    bus.start        = 1'b0;
    bus.pause_toggle = 1'b0;
    bus.game_over    = 1'b0;
    bus.apple_eaten  = 1'b0;
    bus.move_done    = 1'b0;
    if (done_dly > 0) begin
      done_dly--;
      if (done_dly == 0) bus.move_done = 1'b1;
    end
    if (auto_done && bus.move_tick) done_dly = 2;
  endtask

  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      step();
      if (bus.move_tick) at = cyc;
    end
  endtask

  task automatic two_apples();
    bus.apple_eaten = 1'b1;
    step();
    bus.apple_eaten = 1'b1;
    step();
  endtask

  int s, t, prev, nt;

  initial begin
    n_vec = 0; n_miss = 0; cyc = 0; n_ticks = 0; done_dly = 0; auto_done = 1'b0;
    reset = 1'b0;
    bus.start = 1'b0; bus.pause_toggle = 1'b0; bus.game_over = 1'b0;
    bus.apple_eaten = 1'b0; bus.move_done = 1'b0;

    // Reset values
    repeat (3) @(posedge clock_100Mhz);
    #1;
    check("rst_state",   32'(bus.state), 32'(ST_IDLE));
    check("rst_pix",     32'(bus.pixel_ce), 32'd0);
    check("rst_tick",    32'(bus.move_tick), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_level",   32'(bus.level), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);

    // 1. Idle after release: pixel_ce on edges 4, 8, 12; no move ticks
    reset = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("pixel_ce", 32'(bus.pixel_ce), 32'(i % 4 == 0));
    end
    check("idle_ticks", 32'(n_ticks), 32'd0);
    check("idle_state", 32'(bus.state), 32'(ST_IDLE));
    bus.game_over = 1'b1;
    step();
    check("idle_gover", 32'(bus.state), 32'(ST_IDLE));

    // 2. Run at level 0: 20-cycle ticks
    auto_done = 1'b1;
    bus.start = 1'b1;
    step();
    s = cyc;
    check("run_state",   32'(bus.state), 32'(ST_RUN));
    check("run_running", 32'(bus.running), 32'd1);
    wait_tick(30, t);
    check("l0_first", 32'(t - s), 32'd20);
    prev = t;
    wait_tick(30, t);
    check("l0_space", 32'(t - prev), 32'd20);
    check("l0_overrun", 32'(bus.overrun), 32'd0);

    // 3. Levels: new period only after the next expiry; floor at 8, level saturates at 3
    two_apples();
    check("level1", 32'(bus.level), 32'd1);
    prev = t; wait_tick(30, t);
    check("l1_old_space", 32'(t - prev), 32'd20);
    two_apples();
    check("level2", 32'(bus.level), 32'd2);
    prev = t; wait_tick(30, t);
    check("l1_space", 32'(t - prev), 32'd15);
    prev = t; wait_tick(30, t);
    check("l2_space", 32'(t - prev), 32'd10);
    two_apples();
    check("level3", 32'(bus.level), 32'd3);
    prev = t; wait_tick(30, t);
    check("l2_old_space", 32'(t - prev), 32'd10);
    prev = t; wait_tick(30, t);
    check("l3_space", 32'(t - prev), 32'd8);
    two_apples();
    check("level_sat", 32'(bus.level), 32'd3);
    prev = t; wait_tick(30, t);
    check("l3_sat_space", 32'(t - prev), 32'd8);

    // 4. Restart, pause at count 7 for 50 cycles, resume
    bus.start = 1'b1;
    step();
    s = cyc;
    check("restart_level", 32'(bus.level), 32'd0);
    wait_tick(30, t);
    check("restart_space", 32'(t - s), 32'd20);
    repeat (7) step();
    bus.pause_toggle = 1'b1;
    step();
    check("pause_state",   32'(bus.state), 32'(ST_PAUSE));
    check("pause_running", 32'(bus.running), 32'd0);
    nt = n_ticks;
    repeat (50) step();
    check("pause_ticks", 32'(n_ticks - nt), 32'd0);
    check("pause_hold",  32'(bus.state), 32'(ST_PAUSE));
    auto_done = 1'b0;
    bus.pause_toggle = 1'b1;
    s = cyc;
    step();
    check("resume_state", 32'(bus.state), 32'(ST_RUN));
    wait_tick(30, t);
    check("resume_tick", 32'(t - s), 32'd13);

    // 5. Missed move_done -> suppressed tick and sticky overrun; done on expiry -> tick
    repeat (19) step();
    check("ovr_before", 32'(bus.overrun), 32'd0);
    step();
    check("ovr_suppressed", 32'(bus.move_tick), 32'd0);
    check("ovr_set",        32'(bus.overrun), 32'd1);
    repeat (19) step();
    bus.move_done = 1'b1;
    step();
    check("done_on_expiry", 32'(bus.move_tick), 32'd1);
    check("ovr_sticky",     32'(bus.overrun), 32'd1);
    auto_done = 1'b1;
    two_apples();
    check("ovr_level1", 32'(bus.level), 32'd1);
    bus.start = 1'b1;
    step();
    s = cyc;
    check("start_ovr_clr",   32'(bus.overrun), 32'd0);
    check("start_level_clr", 32'(bus.level), 32'd0);
    wait_tick(30, t);
    check("start_busy_clr", 32'(t - s), 32'd20);

    // 6. game_over beats pause_toggle; async reset mid-run
    bus.game_over = 1'b1;
    bus.pause_toggle = 1'b1;
    step();
    check("over_state",   32'(bus.state), 32'(ST_OVER));
    check("over_running", 32'(bus.running), 32'd0);
    nt = n_ticks;
    repeat (25) step();
    check("over_ticks", 32'(n_ticks - nt), 32'd0);
    bus.start = 1'b1;
    step();
    check("over_restart", 32'(bus.state), 32'(ST_RUN));
    two_apples();
    check("pre_rst_level", 32'(bus.level), 32'd1);
    repeat (3) step();
    #3 reset = 1'b0;
    #1;
    check("arst_state",   32'(bus.state), 32'(ST_IDLE));
    check("arst_running", 32'(bus.running), 32'd0);
    check("arst_level",   32'(bus.level), 32'd0);
    check("arst_overrun", 32'(bus.overrun), 32'd0);
    check("arst_tick",    32'(bus.move_tick), 32'd0);
    check("arst_pix",     32'(bus.pixel_ce), 32'd0);
    nt = n_ticks;
    repeat (25) step();
    check("rst_hold_ticks", 32'(n_ticks - nt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
